circuit1_sweep_checker: RTL and testbench

Sequencer and self-checker that sits around the combinational simple circuit (D = (A & B) | ~C, E = ~C). It drives A, B and C, reads back D and E, and compares them with the expected values. On a start pulse it steps through all 8 input vectors in order, samples D/E after a programmable settle time, and counts mismatches. It reports pass/fail and the first failing vector. Used as the on-chip test stage for the gate-level circuit and as a bench-free check in lab builds.

---
 rtl/circuit1_sweep_checker.sv | 144 ++++++++++++++
 tb/tb_circuit1_sweep_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/circuit1_sweep_checker.sv
// Sequencer and self-checker for the simple circuit D = (A & B) | ~C, E = ~C.
// On start it walks all eight {A,B,C} vectors, samples D/E after SETTLE cycles and tallies mismatches.
module circuit1_sweep_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             D,
  input  logic             E,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [3:0]       RELOAD  = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [2:0]       fail_vec_q, fail_vec_d;
  logic             pass_q, pass_d;

  logic sample;
  logic last_vec;
  logic exp_d;
  logic exp_e;
  logic mismatch;

  // Golden response of the circuit for the vector currently driven.
  assign sample   = (state_q == RUN) && (cnt_q == 4'd0);
  assign last_vec = (vec_q == 3'b111);
  assign exp_d    = (vec_q[2] & vec_q[1]) | ~vec_q[0];
  assign exp_e    = ~vec_q[0];
  assign mismatch = sample && ((D != exp_d) || (E != exp_e));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= 3'b000;
      cnt_q        <= 4'd0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'b000;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      pass_q       <= pass_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (sample && last_vec) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    pass_d       = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d        = 3'b000;
          cnt_d        = RELOAD;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'b000;
          pass_d       = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec_q;
            end
          end
          if (!last_vec) begin
            vec_d = vec_q + 3'd1;
            cnt_d = RELOAD;
          end else begin
            // pass must include the result of the final vector sampled here.
            vec_d  = 3'b000;
            pass_d = (err_d == '0);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FIN);
  end

  assign A          = vec_q[2];
  assign B          = vec_q[1];
  assign C          = vec_q[0];
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_circuit1_sweep_checker.sv
// Self-checking bench: two checker instances (SETTLE=2/ERR_W=4 and SETTLE=1/ERR_W=2) around
// a fault-injectable circuit model, compared every cycle against a sweep-timeline reference.
module tb_circuit1_sweep_checker;

  localparam int S0 = 2;
  localparam int W0 = 4;
  localparam int S1 = 1;
  localparam int W1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;   // 0 good, 1 D stuck 0, 2 E = C, 3 D flipped per mask bit
  logic [7:0] mask = 8'h00;

  logic a0, b0, c0, d0, e0, busy0, done0, pass0, fv0;
  logic [W0-1:0] err0;
  logic [2:0] fvec0;
  logic a1, b1, c1, d1, e1, busy1, done1, pass1, fv1;
  logic [W1-1:0] err1;
  logic [2:0] fvec1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic circ_d(input logic [1:0] m, input logic [7:0] msk, input logic [2:0] v);
    logic g;
    g = (v[2] & v[1]) | ~v[0];
    case (m)
      2'd1:    return 1'b0;
      2'd3:    return g ^ msk[v];
      default: return g;
    endcase
  endfunction

  function automatic logic circ_e(input logic [1:0] m, input logic [2:0] v);
    return (m == 2'd2) ? v[0] : ~v[0];
  endfunction

  assign d0 = circ_d(mode, mask, {a0, b0, c0});
  assign e0 = circ_e(mode, {a0, b0, c0});
  assign d1 = circ_d(mode, mask, {a1, b1, c1});
  assign e1 = circ_e(mode, {a1, b1, c1});

  circuit1_sweep_checker #(.SETTLE(S0), .ERR_W(W0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .A(a0), .B(b0), .C(c0), .D(d0), .E(e0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_vec(fvec0));

  circuit1_sweep_checker #(.SETTLE(S1), .ERR_W(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .A(a1), .B(b1), .C(c1), .D(d1), .E(e1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_vec(fvec1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a sweep is a timeline of 8*S RUN cycles followed by one FIN cycle.
  bit started[2] = '{1'b0, 1'b0};
  int k[2] = '{0, 0};
  bit mm[2][8];
  int sl[2] = '{S0, S1};
  int emax[2] = '{(1 << W0) - 1, (1 << W1) - 1};

  function automatic bit model_idle(input int i);
    return !started[i] || (k[i] > 8 * sl[i]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      started[0] = 1'b0;
      started[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start && model_idle(i)) begin
          started[i] = 1'b1;
          k[i] = 0;
          for (int j = 0; j < 8; j++) begin
            logic [2:0] v;
            v = 3'(j);
            mm[i][j] = (circ_d(mode, mask, v) != ((v[2] & v[1]) | ~v[0])) ||
                       (circ_e(mode, v) != ~v[0]);
          end
        end else if (started[i] && k[i] < 100000) begin
          k[i] = k[i] + 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [2:0] abc;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err;
    logic       fv;
    logic [2:0] fvec;
  } obs_t;

  function automatic obs_t expect_obs(input int i);
    obs_t o;
    int s, kk, n, cnt, first, vi;
    o = '0;
    if (!started[i]) return o;
    s = sl[i];
    kk = k[i];
    n = (kk >= 8 * s) ? 8 : kk / s;
    cnt = 0;
    first = -1;
    for (int j = 0; j < n; j++) begin
      if (mm[i][j]) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
    o.err  = 4'((cnt > emax[i]) ? emax[i] : cnt);
    o.fv   = (first >= 0);
    o.fvec = (first >= 0) ? 3'(first) : 3'b000;
    o.busy = (kk < 8 * s);
    o.done = (kk == 8 * s);
    vi = (kk < 8 * s) ? kk / s : 0;
    o.abc  = 3'(vi);
    o.pass = (kk >= 8 * s) && (cnt == 0);
    return o;
  endfunction

  always @(negedge clk) begin
    obs_t act0, act1;
    act0 = '{abc: {a0, b0, c0}, busy: busy0, done: done0, pass: pass0, err: 4'(err0), fv: fv0, fvec: fvec0};
    act1 = '{abc: {a1, b1, c1}, busy: busy1, done: done1, pass: pass1, err: 4'(err1), fv: fv1, fvec: fvec1};
    check("cycle_dut0", 32'(act0), 32'(expect_obs(0)));
    check("cycle_dut1", 32'(act1), 32'(expect_obs(1)));
  end

  int busy_cnt[2];
  int done_cnt[2];

  task automatic run_sweep(input logic [1:0] m, input logic [7:0] msk, input bit repulse);
    @(negedge clk);
    mode = m;
    mask = msk;
    busy_cnt = '{0, 0};
    done_cnt = '{0, 0};
    start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start = repulse && (c == 3);
      if (busy0) busy_cnt[0]++;
      if (busy1) busy_cnt[1]++;
      if (done0) done_cnt[0]++;
      if (done1) done_cnt[1]++;
    end
    start = 1'b0;
    check("idle_after_sweep0", 32'(busy0), 32'd0);
    check("idle_after_sweep1", 32'(busy1), 32'd0);
  endtask

  initial begin
    bit found;
    int dc;
    #1;
    repeat (3) @(negedge clk);
    check("rst_abc", 32'({a0, b0, c0}), 32'd0);
    check("rst_flags", 32'({busy0, done0, pass0, fv0}), 32'd0);
    check("rst_err", 32'({err0, fvec0}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean sweep with a start re-pulse while busy.
    run_sweep(2'd0, 8'h00, 1'b1);
    check("clean_busy_len0", 32'(busy_cnt[0]), 32'd16);
    check("clean_busy_len1", 32'(busy_cnt[1]), 32'd8);
    check("clean_done_cnt0", 32'(done_cnt[0]), 32'd1);
    check("clean_done_cnt1", 32'(done_cnt[1]), 32'd1);
    check("clean_result0", 32'({pass0, err0, fv0}), {27'd0, 1'b1, 4'd0, 1'b0});
    check("clean_pass1", 32'(pass1), 32'd1);

    // D stuck at 0: mismatches at 000, 010, 100, 110, 111.
    run_sweep(2'd1, 8'h00, 1'b0);
    check("dstuck_err0", 32'(err0), 32'd5);
    check("dstuck_fail0", 32'({fv0, fvec0, pass0}), {27'd0, 1'b1, 3'b000, 1'b0});
    check("dstuck_err1_sat", 32'(err1), 32'd3);

    // E inverted: every vector fails.
    run_sweep(2'd2, 8'h00, 1'b0);
    check("einv_err0", 32'(err0), 32'd8);
    check("einv_err1_sat", 32'(err1), 32'd3);
    check("einv_fvec0", 32'({fv0, fvec0, pass0}), {27'd0, 1'b1, 3'b000, 1'b0});

    // Clean sweep after a faulty one clears the results.
    run_sweep(2'd0, 8'h00, 1'b0);
    check("recover_result0", 32'({pass0, err0, fv0}), {27'd0, 1'b1, 4'd0, 1'b0});

    // Reset mid-sweep while vector 011 is driven.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if ({a0, b0, c0} == 3'b011) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_vec011", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_abc", 32'({a0, b0, c0}), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    dc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0) dc++;
    end
    check("midrst_no_done", 32'(dc), 32'd0);
    run_sweep(2'd0, 8'h00, 1'b0);
    check("after_rst_pass0", 32'({pass0, done_cnt[0][1:0]}), 32'b101);

    // Randomised: random fault masks/modes, random start pulses (some ignored).
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (model_idle(0) && model_idle(1) && $urandom_range(0, 3) == 0) begin
        mode = 2'($urandom_range(0, 3));
        mask = 8'($urandom_range(0, 255));
      end
      start = ($urandom_range(0, 5) == 0);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
